lane_accel_sequencer: RTL and testbench
=======================================

// Module: lane_accel_sequencer
// PURPOSE
//   Master-side sequencer for the lane-detection accelerator's flat write/read port.
//   One command runs a full inference: optional soft reset and weight load, frame upload, wait for o_valid, then result-BRAM readout.
//   Sits between the host stream fabric (64-bit in/out streams) and the accelerator top, replacing per-word CPU writes.
// PARAMETERS
//   ADDR_WIDTH     20        accelerator address width
//   OFFSET_OUTPUT  'h6_0000  result BRAM base; frame bytes = OFFSET_OUTPUT (393216 B = 49152 beats)
//   OUTPUT_BYTES   2048      result bytes (256 beats)
//   OFFSET_RESET   'h6_0810  soft-reset register
//   OFFSET_WEIGHT  'h6_0818  weight window base
//   WEIGHT_BYTES   152646    weight bytes (19081 beats; last beat strobe 8'h3F)
//   RESET_WAIT     16        idle cycles after soft-reset write
//   TIMEOUT_CYCLES 2**24     WAIT_DONE limit (SEQ_TIMEOUT_EN only)
// PORTS
//   clk            in   1   clock
//   rst_n          in   1   asynchronous reset, active-low
//   cmd_start      in   1   start pulse; accepted only in IDLE
//   cmd_weights    in   1   sampled with cmd_start: 1 = soft reset + weight load first
//   seq_busy       out  1   high in every state except IDLE
//   seq_done       out  1   1-cycle pulse when run ends
//   seq_err        out  1   1-cycle pulse with seq_done on timeout
//   src_data       in   64  weight beats then frame beats, in order
//   src_valid      in   1   source valid
//   src_ready      out 1   source ready
//   res_data       out  64  result bytes, little-endian per beat
//   res_valid      out  1   result valid
//   res_last       out  1   high on the 256th beat
//   res_ready      in   1   result ready
//   acc_wr_data    out  64  accelerator write data
//   acc_wr_addr    out  ADDR_WIDTH
//   acc_wr_en      out  1
//   acc_wr_strobe  out  8
//   acc_wready     in   1   accelerator write-ready
//   acc_rd_addr    out  ADDR_WIDTH
//   acc_rd_en      out  1
//   acc_rd_data    in   64  valid the cycle after acc_rd_en
//   acc_o_valid    in   1   inference complete
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; acc_wr_strobe 0; acc_rd_addr = OFFSET_OUTPUT.
//   FSM: IDLE -> (cmd_weights ? SRST : FRAME).
//   FSM: SRST -> SRST_WAIT -> WEIGHTS -> FRAME -> WAIT_DONE -> READOUT -> IDLE.
//   SRST: one write, addr OFFSET_RESET, data 64'h1, strobe 8'h01; ignores acc_wready.
//   SRST_WAIT: counts RESET_WAIT cycles with no accesses.
//   WEIGHTS/FRAME write rule:
//     - src_ready = acc_wready; a write fires when src_valid & src_ready.
//     - acc_wr_* are registered: the write appears 1 cycle after the handshake.
//     - Address starts at OFFSET_WEIGHT or 0 and steps +8 per beat.
//     - Strobe is 8'hFF, except 8'h3F on the last weight beat.
//     - Beat counter leaves the state on its last beat; no extra beat is consumed.
//   WAIT_DONE: src_ready=0; exits on acc_o_valid (level, checked every cycle).
//   READOUT read issue:
//     - A read issues when the 2-entry skid buffer will have space.
//     - acc_rd_addr is loaded at issue and held until the next issue.
//     - Data captured at issue+1 goes into the skid buffer; at most one read is in flight.
//   READOUT completion:
//     - After 256 reads issue, the FSM waits for the buffer to drain.
//     - seq_done pulses on the cycle the res_last beat is accepted; state returns to IDLE.
//   res_valid/res_data hold stable until res_ready; no combinational res_ready->res_valid path.
//   cmd_start while busy: ignored, no effect.
//   acc_o_valid outside WAIT_DONE: ignored.
//   rst_n mid-run: immediate return to reset state; skid buffer is flushed.
// CONFIGURATION
//   SEQ_TIMEOUT_EN defined:
//     - 32-bit counter in WAIT_DONE.
//     - Reaching TIMEOUT_CYCLES pulses seq_err and seq_done together and returns to IDLE; no readout.
//   SEQ_TIMEOUT_EN undefined: WAIT_DONE waits forever; seq_err tied 0.
// STRUCTURE
//   Package lane_seq_pkg: state enum, offset/beat-count localparams, strobe constants.
//   Sub-module seq_skid_buffer: 2-entry 64+1-bit buffer with valid/ready on both sides.
//   Top level: FSM, beat/read counters, write and read drivers.
// TESTING
//   cmd_start, cmd_weights=1 -> one reset write (addr 'h6_0810, data 1), 16 idle cycles.
//     Then 19081 weight writes 'h6_0818..'h8_5C58, last strobe 8'h3F; then 49152 frame writes 0..'h5_FFF8.
//   acc_wready low 50 cycles mid-frame -> src_ready=0, no acc_wr_en; no beat lost or duplicated.
//   acc_o_valid after readout starts -> 256 reads 'h6_0000..'h6_07F8.
//     res_data matches the model BRAM; res_last on beat 256; seq_done the same cycle it is accepted.
//   res_ready random 30% duty -> output order intact; no read issues while the buffer is full.
//   cmd_start in FRAME -> ignored; rst_n low mid-WEIGHTS -> all outputs 0 next edge, IDLE.
//   SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, no acc_o_valid -> seq_err=seq_done=1 at cycle 100; no reads.

Source files
------------

// File: rtl/lane_seq_pkg.sv
// Shared state encoding, address map and beat counts for the lane accelerator sequencer.
package lane_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSrst,
    StSrstWait,
    StWeights,
    StFrame,
    StWaitDone,
    StReadout
  } seq_state_e;

  localparam int unsigned AddrWidth    = 20;
  localparam int unsigned OffsetOutput = 32'h6_0000;
  localparam int unsigned OffsetReset  = 32'h6_0810;
  localparam int unsigned OffsetWeight = 32'h6_0818;
  localparam int unsigned OutputBytes  = 2048;
  localparam int unsigned WeightBytes  = 152646;
  localparam int unsigned ResetWait    = 16;

  // The frame fills the address space below the result BRAM.
  localparam int unsigned FrameBeats   = OffsetOutput / 8;
  localparam int unsigned WeightBeats  = (WeightBytes + 7) / 8;
  localparam int unsigned OutputBeats  = OutputBytes / 8;

  localparam int unsigned BeatW        = 17;
  localparam int unsigned RdCntW       = 9;

  localparam logic [7:0]  StrbFull       = 8'hFF;
  localparam logic [7:0]  StrbWeightLast = 8'h3F;
  localparam logic [7:0]  StrbReset      = 8'h01;
  localparam logic [63:0] ResetData      = 64'h1;

endpackage

// File: rtl/seq_skid_buffer.sv
// Two-entry FIFO skid buffer; outputs come straight from storage so out_valid_o never
// depends combinationally on out_ready_i.
module seq_skid_buffer #(
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lane_accel_sequencer.sv
// Master-side sequencer: soft reset and weight load, frame upload, completion wait and result
// readout over the accelerator's flat port. Build option SEQ_TIMEOUT_EN adds a WAIT_DONE timeout.
module lane_accel_sequencer
  import lane_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AddrWidth,
  parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic                  cmd_weights,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_err,
  input  logic [63:0]           src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [63:0]           res_data,
  output logic                  res_valid,
  output logic                  res_last,
  input  logic                  res_ready,
  output logic [63:0]           acc_wr_data,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic                  acc_wr_en,
  output logic [7:0]            acc_wr_strobe,
  input  logic                  acc_wready,
  output logic [ADDR_WIDTH-1:0] acc_rd_addr,
  output logic                  acc_rd_en,
  input  logic [63:0]           acc_rd_data,
  input  logic                  acc_o_valid
);

  localparam logic [ADDR_WIDTH-1:0] AddrReset  = ADDR_WIDTH'(OffsetReset);
  localparam logic [ADDR_WIDTH-1:0] AddrWeight = ADDR_WIDTH'(OffsetWeight);
  localparam logic [ADDR_WIDTH-1:0] AddrOutput = ADDR_WIDTH'(OffsetOutput);
  localparam logic [BeatW-1:0]      WaitLast   = BeatW'(ResetWait - 1);
  localparam logic [BeatW-1:0]      WeightLast = BeatW'(WeightBeats - 1);
  localparam logic [BeatW-1:0]      FrameLast  = BeatW'(FrameBeats - 1);
  localparam logic [RdCntW-1:0]     RdTotal    = RdCntW'(OutputBeats);
  localparam logic [RdCntW-1:0]     RdLast     = RdCntW'(OutputBeats - 1);

  seq_state_e              state_q, state_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [63:0]             wr_data_q, wr_data_d;
  logic [7:0]              wr_strb_q, wr_strb_d;
  logic [RdCntW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    rd_issue;
  logic                    rd_en_q, rd_en_last_q;
  logic                    rd_pend_q, pend_last_q;
  logic                    buf_in_ready;
  logic [64:0]             buf_out;
  logic                    last_acc;
  logic [ADDR_WIDTH-1:0]   beat_off;
`ifdef SEQ_TIMEOUT_EN
  logic [31:0]             to_cnt_q;
  logic                    timeout_hit;
`endif

  assign beat_off = ADDR_WIDTH'({beat_q, 3'b000});
  assign last_acc = res_valid & res_ready & res_last;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = '0;
    src_ready = 1'b0;
    rd_issue  = 1'b0;
    rd_cnt_d  = rd_cnt_q;
    rd_addr_d = rd_addr_q;
`ifdef SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_start) begin
          beat_d   = '0;
          rd_cnt_d = '0;
          state_d  = cmd_weights ? StSrst : StFrame;
        end
      end
      StSrst: begin
        wr_en_d   = 1'b1;
        wr_addr_d = AddrReset;
        wr_data_d = ResetData;
        wr_strb_d = StrbReset;
        beat_d    = '0;
        state_d   = StSrstWait;
      end
      StSrstWait: begin
        if (beat_q == WaitLast) begin
          beat_d  = '0;
          state_d = StWeights;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StWeights: begin
        src_ready = acc_wready;
        if (src_valid && acc_wready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = AddrWeight + beat_off;
          wr_data_d = src_data;
          if (beat_q == WeightLast) begin
            wr_strb_d = StrbWeightLast;
            beat_d    = '0;
            state_d   = StFrame;
          end else begin
            wr_strb_d = StrbFull;
            beat_d    = beat_q + 1'b1;
          end
        end
      end
      StFrame: begin
        src_ready = acc_wready;
        if (src_valid && acc_wready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = beat_off;
          wr_data_d = src_data;
          wr_strb_d = StrbFull;
          if (beat_q == FrameLast) begin
            beat_d  = '0;
            state_d = StWaitDone;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StWaitDone: begin
        if (acc_o_valid) begin
          state_d = StReadout;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end
`endif
      end
      StReadout: begin
        // One read in flight at most; a free slot now stays free until its data lands.
        if (rd_cnt_q != RdTotal && !rd_en_q && !rd_pend_q && buf_in_ready) begin
          rd_issue  = 1'b1;
          rd_addr_d = AddrOutput + ADDR_WIDTH'({rd_cnt_q, 3'b000});
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (last_acc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
      rd_cnt_q     <= '0;
      rd_addr_q    <= AddrOutput;
      rd_en_q      <= 1'b0;
      rd_en_last_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_strb_q    <= wr_strb_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_issue;
      rd_en_last_q <= rd_issue & (rd_cnt_q == RdLast);
      rd_pend_q    <= rd_en_q;
      pend_last_q  <= rd_en_last_q;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == StWaitDone) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign seq_err  = timeout_hit;
  assign seq_done = last_acc | timeout_hit;
`else
  assign seq_err  = 1'b0;
  assign seq_done = last_acc;
`endif

  seq_skid_buffer #(
    .Width(65)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_data_i  ({pend_last_q, acc_rd_data}),
    .in_valid_i (rd_pend_q),
    .in_ready_o (buf_in_ready),
    .out_data_o (buf_out),
    .out_valid_o(res_valid),
    .out_ready_i(res_ready)
  );

  assign res_data      = buf_out[63:0];
  assign res_last      = buf_out[64];
  assign seq_busy      = (state_q != StIdle);
  assign acc_wr_en     = wr_en_q;
  assign acc_wr_addr   = wr_addr_q;
  assign acc_wr_data   = wr_data_q;
  assign acc_wr_strobe = wr_strb_q;
  assign acc_rd_en     = rd_en_q;
  assign acc_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_lane_accel_sequencer.sv
// Directed bench for lane_accel_sequencer: full weight+frame run, stall, readout, reset mid-run.
module tb_lane_accel_sequencer;

  localparam int WBeats  = 19081;
  localparam int FBeats  = 49152;
  localparam int NWrites = 1 + WBeats + FBeats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_start = 1'b0, cmd_weights = 1'b0;
  logic        seq_busy, seq_done, seq_err;
  logic [63:0] src_data = '0;
  logic        src_valid = 1'b0, src_ready;
  logic [63:0] res_data;
  logic        res_valid, res_last, res_ready = 1'b0;
  logic [63:0] acc_wr_data;
  logic [19:0] acc_wr_addr;
  logic        acc_wr_en;
  logic [7:0]  acc_wr_strobe;
  logic        acc_wready = 1'b0;
  logic [19:0] acc_rd_addr;
  logic        acc_rd_en;
  logic [63:0] acc_rd_data = '0;
  logic        acc_o_valid = 1'b0;

  always #5 clk = ~clk;

  lane_accel_sequencer #(
    .ADDR_WIDTH    (20),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start    (cmd_start),
    .cmd_weights  (cmd_weights),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .res_last     (res_last),
    .res_ready    (res_ready),
    .acc_wr_data  (acc_wr_data),
    .acc_wr_addr  (acc_wr_addr),
    .acc_wr_en    (acc_wr_en),
    .acc_wr_strobe(acc_wr_strobe),
    .acc_wready   (acc_wready),
    .acc_rd_addr  (acc_rd_addr),
    .acc_rd_en    (acc_rd_en),
    .acc_rd_data  (acc_rd_data),
    .acc_o_valid  (acc_o_valid)
  );

  function automatic logic [63:0] src_word(int k);
    return {32'(k) * 32'h9E37_79B9, 32'(k) ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [63:0] ram_word(logic [19:0] a);
    return {12'hACC, a, {12'h000, a} * 32'h0101_0101};
  endfunction

  function automatic logic [19:0] exp_addr(int w);
    if (w == 0) return 20'h60810;
    if (w <= WBeats) return 20'h60818 + 20'((w - 1) * 8);
    return 20'((w - WBeats - 1) * 8);
  endfunction

  function automatic logic [7:0] exp_strb(int w);
    if (w == 0) return 8'h01;
    if (w == WBeats) return 8'h3F;
    return 8'hFF;
  endfunction

  function automatic logic [63:0] exp_data(int w);
    if (w == 0) return 64'h1;
    return src_word(w - 1);
  endfunction

  // Accelerator result BRAM: data valid the cycle after acc_rd_en.
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= ram_word(acc_rd_addr);
    else acc_rd_data <= 64'hDEAD_DEAD_DEAD_DEAD;
  end

  typedef struct {
    int          idx;
    logic [19:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_vec_t;

  wr_vec_t     vecs [8];
  logic [19:0] log_addr [NWrites];
  logic [63:0] log_data [NWrites];
  logic [7:0]  log_strb [NWrites];
  int          log_cyc [2];

  int n_checks = 0, n_err = 0;
  int cyc = 0, wr_n = 0, wr_bad = 0, rd_n = 0, rd_bad = 0, rd_over = 0;
  int acc_n = 0, res_bad = 0, done_bad = 0, done_n = 0, stab_bad = 0, err_bad = 0;
  int src_idx = 0;
  bit log_en = 0, valid_mode = 0, src_on = 0, wready_on = 0, rr_mode = 0;
  bit hold_q = 0;
  logic [63:0] hold_data = '0;
  logic        hold_last = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (acc_wr_en) begin
      if (log_en) begin
        if (wr_n < NWrites) begin
          log_addr[wr_n] = acc_wr_addr;
          log_data[wr_n] = acc_wr_data;
          log_strb[wr_n] = acc_wr_strobe;
          if (wr_n < 2) log_cyc[wr_n] = cyc;
          if (acc_wr_addr !== exp_addr(wr_n) || acc_wr_data !== exp_data(wr_n) ||
              acc_wr_strobe !== exp_strb(wr_n)) wr_bad++;
        end else begin
          wr_bad++;
        end
      end
      wr_n++;
    end
    if (acc_rd_en) begin
      if (acc_rd_addr !== 20'h60000 + 20'(rd_n * 8)) rd_bad++;
      rd_n++;
      if (rd_n - acc_n > 2) rd_over++;
    end
    if (hold_q && (!res_valid || res_data !== hold_data || res_last !== hold_last)) stab_bad++;
`ifndef SEQ_TIMEOUT_EN
    if (seq_err) err_bad++;
`endif
    src_data   = src_word(src_idx);
    src_valid  = valid_mode ? (cyc % 3 != 0) : src_on;
    acc_wready = wready_on;
    res_ready  = rr_mode ? ($urandom_range(0, 9) < 3) : 1'b0;
    #1;
    if (src_valid && src_ready) src_idx++;
    hold_q    = res_valid && !res_ready;
    hold_data = res_data;
    hold_last = res_last;
    if (seq_done) done_n++;
    if (res_valid && res_ready) begin
      if (res_data !== ram_word(20'h60000 + 20'(acc_n * 8)) || res_last !== (acc_n == 255))
        res_bad++;
      if (seq_done !== res_last) done_bad++;
      acc_n++;
    end else if (seq_done && !seq_err) begin
      done_bad++;
    end
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_busy"}, 64'(seq_busy), 64'd0);
    chk({tag, "_done"}, 64'(seq_done), 64'd0);
    chk({tag, "_err"}, 64'(seq_err), 64'd0);
    chk({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_last"}, 64'(res_last), 64'd0);
    chk({tag, "_res_data"}, res_data, 64'd0);
    chk({tag, "_wr_en"}, 64'(acc_wr_en), 64'd0);
    chk({tag, "_wr_strobe"}, 64'(acc_wr_strobe), 64'd0);
    chk({tag, "_wr_addr"}, 64'(acc_wr_addr), 64'd0);
    chk({tag, "_wr_data"}, acc_wr_data, 64'd0);
    chk({tag, "_rd_en"}, 64'(acc_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(acc_rd_addr), 64'h60000);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, wd, stall_rdy_bad, wd_bad, k;
    vecs[0] = '{0,      20'h60810, 64'h1,              8'h01};
    vecs[1] = '{1,      20'h60818, src_word(0),        8'hFF};
    vecs[2] = '{2,      20'h60820, src_word(1),        8'hFF};
    vecs[3] = '{19080,  20'h85C50, src_word(19079),    8'hFF};
    vecs[4] = '{19081,  20'h85C58, src_word(19080),    8'h3F};
    vecs[5] = '{19082,  20'h00000, src_word(19081),    8'hFF};
    vecs[6] = '{19083,  20'h00008, src_word(19082),    8'hFF};
    vecs[7] = '{68233,  20'h5FFF8, src_word(68232),    8'hFF};

    #2 rst_n = 1'b0;
    repeat (3) step();
    check_reset("reset");
    rst_n = 1'b1;
    step();

    // Completion flag while idle must not start anything.
    acc_o_valid = 1'b1;
    step();
    acc_o_valid = 1'b0;
    step();
    chk("idle_o_valid_ignored", 64'(seq_busy), 64'd0);

    log_en = 1; wready_on = 1; src_on = 1;
    cmd_weights = 1'b1; cmd_start = 1'b1;
    step();
    cmd_start = 1'b0; cmd_weights = 1'b0;
    step();
    chk("busy_after_start", 64'(seq_busy), 64'd1);

    for (k = 0; k < 200 && wr_n < 2; k++) step();
    valid_mode = 1;
    for (k = 0; k < 2000 && wr_n < 300; k++) step();
    valid_mode = 0;
    chk("gap_reset_to_first_weight", 64'(log_cyc[1] - log_cyc[0]), 64'd17);

    for (k = 0; k < 45000 && wr_n < 40000; k++) step();
    chk("reached_mid_frame", 64'(wr_n >= 40000), 64'd1);
    // Start and completion flag mid-frame are both ignored; the write stream shows it.
    cmd_weights = 1'b1; cmd_start = 1'b1; acc_o_valid = 1'b1;
    step();
    cmd_weights = 1'b0; cmd_start = 1'b0; acc_o_valid = 1'b0;

    wready_on = 0;
    stall_rdy_bad = 0;
    step();
    if (src_ready) stall_rdy_bad++;
    w0 = wr_n;
    for (int i = 0; i < 49; i++) begin
      step();
      if (src_ready) stall_rdy_bad++;
    end
    chk("stall_no_writes", 64'(wr_n - w0), 64'd0);
    chk("stall_src_ready_low", 64'(stall_rdy_bad), 64'd0);
    wready_on = 1;

    for (k = 0; k < 35000 && wr_n < NWrites; k++) step();
    chk("write_count", 64'(wr_n), 64'(NWrites));
    wd = 1;

`ifdef SEQ_TIMEOUT_EN
    for (k = 0; k < 300 && !seq_err; k++) begin
      step();
      wd++;
    end
    chk("timeout_cycle", 64'(wd), 64'd100);
    chk("timeout_done", 64'(seq_done), 64'd1);
    chk("timeout_no_reads", 64'(rd_n), 64'd0);
    step();
    chk("timeout_idle", 64'(seq_busy), 64'd0);
`else
    wd_bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (seq_busy !== 1'b1 || seq_done || acc_rd_en || src_ready) wd_bad++;
    end
    chk("wait_done_holds", 64'(wd_bad), 64'd0);
    chk("wait_done_no_reads", 64'(rd_n), 64'd0);

    acc_o_valid = 1'b1;
    rr_mode = 1;
    for (k = 0; k < 5000 && acc_n < 256; k++) step();
    acc_o_valid = 1'b0;
    rr_mode = 0;
    chk("readout_accepted", 64'(acc_n), 64'd256);
    chk("readout_reads", 64'(rd_n), 64'd256);
    chk("readout_addr_bad", 64'(rd_bad), 64'd0);
    chk("readout_data_bad", 64'(res_bad), 64'd0);
    chk("read_while_full", 64'(rd_over), 64'd0);
    chk("res_hold_stable", 64'(stab_bad), 64'd0);
    chk("done_pulses", 64'(done_n), 64'd1);
    step();
    chk("idle_after_readout", 64'(seq_busy), 64'd0);
`endif
    chk("done_misplaced", 64'(done_bad), 64'd0);
    chk("stream_writes_bad", 64'(wr_bad), 64'd0);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_addr", i), 64'(log_addr[vecs[i].idx]), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_data", i), log_data[vecs[i].idx], vecs[i].data);
      chk($sformatf("vec%0d_strb", i), 64'(log_strb[vecs[i].idx]), 64'(vecs[i].strb));
    end

    // Asynchronous reset in the middle of the weight load.
    log_en = 0;
    cmd_weights = 1'b1; cmd_start = 1'b1;
    step();
    cmd_weights = 1'b0; cmd_start = 1'b0;
    w0 = wr_n;
    for (k = 0; k < 200 && wr_n < w0 + 30; k++) step();
    chk("weights_in_progress", 64'(seq_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midrun_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_midrun_reset", 64'(seq_busy), 64'd0);
    chk("no_src_after_reset", 64'(src_ready), 64'd0);
    chk("seq_err_stuck", 64'(err_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
